// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster scan generator.
// One pixel slot is four clk cycles (phase 0..3). The pixel generator is asked
// for the next pixel with a one-cycle req strobe in phase 3, and the colour it
// returns is captured on the edge that ends phase 0 of the following slot.
// Column/row ordering inside a line/frame is back porch, visible, front porch,
// sync, so the sync pulses sit at the very end of each line and frame.
module vga_scan_ctrl #(
    parameter int H_TOTAL = 800,  // pixel slots per line
    parameter int V_TOTAL = 525,  // lines per frame
    // Porch/sync geometry; front porch is whatever remains of the total.
    parameter int H_BP    = 48,
    parameter int H_VIS   = 640,
    parameter int H_SYNC  = 96,
    parameter int V_BP    = 33,
    parameter int V_VIS   = 480,
    parameter int V_SYNC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] next_color,
    output logic       req,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic [9:0] next_col,
    output logic [9:0] next_row,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue,
    output logic       frame_start
);

    // Timing boundaries, all held in 10 bits (max position 1023).
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_START  = 10'(H_BP);
    localparam logic [9:0] H_VIS_END    = 10'(H_BP + H_VIS);   // exclusive
    localparam logic [9:0] V_VIS_START  = 10'(V_BP);
    localparam logic [9:0] V_VIS_END    = 10'(V_BP + V_VIS);   // exclusive
    localparam logic [9:0] H_SYNC_START = 10'(H_TOTAL - H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_TOTAL - V_SYNC);

    localparam logic [1:0] PH_LAST = 2'd3;

    logic [1:0] phase_q, phase_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic [9:0] next_col_q, next_col_d;
    logic [9:0] next_row_q, next_row_d;
    logic       req_q, req_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [7:0] color_q, color_d;
    logic       frame_start_q, frame_start_d;

    logic       slot_end;
    logic       col_wrap;
    logic       row_wrap;
    logic       visible;

    // Slot phase and scan position for the next cycle.
    always_comb begin
        phase_d  = phase_q + 2'd1;
        slot_end = (phase_q == PH_LAST);
        col_wrap = (col_q == H_LAST);
        row_wrap = (row_q == V_LAST);
        col_d    = col_q;
        row_d    = row_q;
        if (slot_end) begin
            if (col_wrap) begin
                col_d = 10'd0;
                row_d = row_wrap ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Look-ahead position, sync and strobe flags derived from the next
    // position so they change on the same edge as col/row.
    always_comb begin
        if (col_d == H_LAST) begin
            next_col_d = 10'd0;
            next_row_d = (row_d == V_LAST) ? 10'd0 : row_d + 10'd1;
        end else begin
            next_col_d = col_d + 10'd1;
            next_row_d = row_d;
        end
        hsync_d       = !(col_d >= H_SYNC_START);
        vsync_d       = !(row_d >= V_SYNC_START);
        req_d         = (phase_d == PH_LAST);
        frame_start_d = (phase_d == 2'd0) && (col_d == 10'd0) && (row_d == 10'd0);
    end

    // Colour capture at the end of phase 0; blanked outside the active area.
    always_comb begin
        visible = (col_q >= H_VIS_START) && (col_q < H_VIS_END) &&
                  (row_q >= V_VIS_START) && (row_q < V_VIS_END);
        color_d = color_q;
        if (phase_q == 2'd0) begin
            color_d = visible ? next_color : 8'd0;
        end
    end

    // State registers; reset abandons any slot/frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= 2'd0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            next_col_q    <= 10'd1;
            next_row_q    <= 10'd0;
            req_q         <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            color_q       <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            col_q         <= col_d;
            row_q         <= row_d;
            next_col_q    <= next_col_d;
            next_row_q    <= next_row_d;
            req_q         <= req_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            color_q       <= color_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign req         = req_q;
    assign col         = col_q;
    assign row         = row_q;
    assign next_col    = next_col_q;
    assign next_row    = next_row_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_red     = color_q[7:5];
    assign vga_green   = color_q[4:2];
    assign vga_blue    = color_q[1:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed bench. A default-geometry instance covers the
// line-level timing (640x480 columns); a reduced-geometry instance
// (20 slots x 12 lines: bp 3/vis 10/sync 4, bp 2/vis 6/sync 2) keeps whole
// frames short enough to walk through.
module tb_vga_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] next_color;

    logic       d_req, d_hs, d_vs, d_fs;
    logic [9:0] d_col, d_row, d_ncol, d_nrow;
    logic [2:0] d_r, d_g;
    logic [1:0] d_b;

    logic       s_req, s_hs, s_vs, s_fs;
    logic [9:0] s_col, s_row, s_ncol, s_nrow;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .next_color(next_color), .req(d_req),
        .col(d_col), .row(d_row), .next_col(d_ncol), .next_row(d_nrow),
        .hsync(d_hs), .vsync(d_vs), .vga_red(d_r), .vga_green(d_g),
        .vga_blue(d_b), .frame_start(d_fs)
    );

    vga_scan_ctrl #(
        .H_TOTAL(20), .V_TOTAL(12), .H_BP(3), .H_VIS(10), .H_SYNC(4),
        .V_BP(2), .V_VIS(6), .V_SYNC(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .next_color(next_color), .req(s_req),
        .col(s_col), .row(s_row), .next_col(s_ncol), .next_row(s_nrow),
        .hsync(s_hs), .vsync(s_vs), .vga_red(s_r), .vga_green(s_g),
        .vga_blue(s_b), .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clk; land mid-cycle (falling edge) for sampling.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        #1;
    endtask

    initial begin
        int hs_lo, vs_lo, vis, fs_cnt;
        rst_n      = 1'b0;
        next_color = 8'hE3;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_req",   d_req, 0);
        chk("rst_col",   d_col, 0);
        chk("rst_row",   d_row, 0);
        chk("rst_ncol",  d_ncol, 1);
        chk("rst_nrow",  d_nrow, 0);
        chk("rst_sync",  {d_hs, d_vs}, 2'b11);
        chk("rst_color", {d_r, d_g, d_b}, 0);
        chk("rst_fs",    d_fs, 0);

        // First 16 cycles: req only in phase 3, col steps per slot
        release_reset();
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("req_c%0d", c), d_req, (c % 4 == 3) ? 1 : 0);
            if (c % 4 == 0) chk($sformatf("col_c%0d", c), d_col, c / 4);
            if (c < 15) step();
        end

        // End of line 0 and wrap into line 1
        goto(799*4 + 3);
        chk("eol_pos",  {d_col, d_row}, {10'd799, 10'd0});
        chk("eol_req",  d_req, 1);
        chk("eol_hs",   d_hs, 0);
        chk("eol_next", {d_ncol, d_nrow}, {10'd0, 10'd1});
        step();
        chk("wrap_pos",  {d_col, d_row}, {10'd0, 10'd1});
        chk("wrap_next", {d_ncol, d_nrow}, {10'd1, 10'd1});
        chk("wrap_hs",   d_hs, 1);
        chk("wrap_vs",   d_vs, 1);

        // hsync-low slots over line 1
        hs_lo = 0;
        repeat (800) begin
            if (!d_hs) hs_lo++;
            repeat (4) step();
        end
        chk("hs_slots_line", hs_lo, 96);
        chk("line2_pos", {d_col, d_row}, {10'd0, 10'd2});

        // Reduced geometry from here on
        rst_n = 1'b0;
        @(negedge clk);
        release_reset();

        // Frame boundary: slot (19,11) phase 3 -> (0,0)
        goto(239*4 + 3);
        chk("eof_pos",  {s_col, s_row}, {10'd19, 10'd11});
        chk("eof_sync", {s_hs, s_vs}, 2'b00);
        chk("eof_next", {s_ncol, s_nrow}, {10'd0, 10'd0});
        chk("eof_fs",   s_fs, 0);
        step();
        chk("sof_pos",  {s_col, s_row}, {10'd0, 10'd0});
        chk("sof_fs",   s_fs, 1);
        chk("sof_sync", {s_hs, s_vs}, 2'b11);

        // Whole second frame (960 clk): sync, visibility and frame_start tallies
        hs_lo = 0; vs_lo = 0; vis = 0; fs_cnt = 0;
        repeat (960) begin
            if (cyc % 4 == 0) begin
                if (!s_hs) hs_lo++;
                if (!s_vs) vs_lo++;
            end
            if ((cyc % 4 == 1) && ({s_r, s_g, s_b} != 8'd0)) vis++;
            if (s_fs) fs_cnt++;
            step();
        end
        chk("hs_slots_frame", hs_lo, 4*12);
        chk("vs_slots_frame", vs_lo, 2*20);
        chk("vis_slots",      vis, 60);
        chk("fs_per_frame",   fs_cnt, 1);

        // Colour latch around the visible window (frame 3 starts at clk 1920)
        goto(1920 + (1*20 + 3)*4 + 1);
        chk("col_row_above", {s_r, s_g, s_b}, 0);
        goto(1920 + (2*20 + 2)*4 + 1);
        chk("col_left_edge", {s_r, s_g, s_b}, 0);
        goto(1920 + (2*20 + 3)*4 + 1);
        chk("first_vis_r", s_r, 3'b111);
        chk("first_vis_g", s_g, 3'b000);
        chk("first_vis_b", s_b, 2'b11);
        next_color = 8'h1C;
        step(); step();
        chk("color_hold", {s_r, s_g, s_b}, 8'hE3);
        goto(1920 + (7*20 + 12)*4 + 1);
        chk("last_vis", {s_r, s_g, s_b}, {3'b000, 3'b111, 2'b00});
        goto(1920 + (7*20 + 13)*4 + 1);
        chk("col_right_edge", {s_r, s_g, s_b}, 0);
        goto(1920 + (8*20 + 3)*4 + 1);
        chk("row_below", {s_r, s_g, s_b}, 0);

        // Reset mid-slot, mid-frame (frame 4 starts at clk 2880)
        goto(2880 + (5*20 + 9)*4 + 2);
        chk("pre_rst_pos", {s_col, s_row}, {10'd9, 10'd5});
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pos",   {s_col, s_row}, 0);
        chk("arst_next",  {s_ncol, s_nrow}, {10'd1, 10'd0});
        chk("arst_req",   s_req, 0);
        chk("arst_sync",  {s_hs, s_vs}, 2'b11);
        chk("arst_color", {s_r, s_g, s_b}, 0);
        chk("arst_fs",    s_fs, 0);
        @(negedge clk);
        release_reset();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rr_req_c%0d", c), s_req, (c == 3) ? 1 : 0);
            chk($sformatf("rr_col_c%0d", c), s_col, (c == 4) ? 1 : 0);
            if (c < 4) step();
        end
        chk("rr_row", s_row, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
